// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add controller.
// Holds the controller state encoding, the adder slice width and a helper
// that derives the number of slices from the operand width.
package nibble_serial_add_ctrl_pkg;

  // Width of one adder slice (the external adder is 4 bits wide).
  localparam int NIB_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of nibble slices needed to cover an operand of the given width.
  function automatic int num_slices(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Adds two WIDTH-bit operands by feeding them LSB-first, one nibble at a time,
// through an external 4-bit adder with ADD_LAT cycles of latency. Each slice's
// carry-out is chained into the next slice's carry-in.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_in_valid / o_in_ready   operand handshake (ready only when idle)
//   i_in_a, i_in_b, i_in_cin  operands and initial carry-in
//   o_add_a, o_add_b, o_add_cin   nibble and carry to the adder (0 unless issuing)
//   i_add_sum, i_add_cout     adder result, valid ADD_LAT cycles after issue
//   o_out_valid / i_out_ready result handshake
//   o_out_sum, o_out_cout     WIDTH-bit sum and final carry-out
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic             i_in_cin,
  output logic [NIB_W-1:0] o_add_a,
  output logic [NIB_W-1:0] o_add_b,
  output logic             o_add_cin,
  input  logic [NIB_W-1:0] i_add_sum,
  input  logic             i_add_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic             o_out_cout
);

  localparam int N     = num_slices(WIDTH);
  localparam int CNT_W = $clog2(ADD_LAT + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] LAT_LD   = CNT_W'(ADD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;

  logic             w_accept;
  logic             w_capture;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [NIB_W-1:0] w_add_a;
  logic [NIB_W-1:0] w_add_b;
  logic             w_add_cin;

  assign w_last = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake/adder outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_add_a     = '0;
    w_add_b     = '0;
    w_add_cin   = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // in_ready is held low while reset is asserted.
        w_in_ready = ~i_rst;
        w_accept   = i_in_valid & ~i_rst;
        if (w_accept) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_add_a     = r_a[r_idx*NIB_W +: NIB_W];
        w_add_b     = r_b[r_idx*NIB_W +: NIB_W];
        w_add_cin   = r_carry;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Counter is loaded with ADD_LAT on issue, so a value of 1 marks
        // the cycle in which the adder presents this slice's result.
        if (r_cnt == CNT_ONE) begin
          w_capture = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand, result, carry, wait-counter and slice-index registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= i_in_a;
        r_b      <= i_in_b;
        r_carry  <= i_in_cin;
        r_idx    <= '0;
        r_result <= '0;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= LAT_LD;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (w_capture) begin
        r_result[r_idx*NIB_W +: NIB_W] <= i_add_sum;
        r_carry                        <= i_add_cout;
        if (!w_last) begin
          r_idx <= r_idx + IDX_ONE;
        end
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_add_a     = w_add_a;
  assign o_add_b     = w_add_b;
  assign o_add_cin   = w_add_cin;
  assign o_out_sum   = r_result;
  assign o_out_cout  = r_carry;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl wired to a 4-bit, two-stage adder.
// A transaction-level model tracks the expected handshake timing, adder
// inputs and result; a negedge process compares the DUT against it every
// cycle. Directed cases pin the model with hand-computed values.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH   = 16;
  localparam int ADD_LAT = 2;
  localparam int N       = WIDTH / 4;
  localparam int STEP    = 1 + ADD_LAT;
  localparam int TOTAL   = N * STEP;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_a      (in_a),
    .i_in_b      (in_b),
    .i_in_cin    (in_cin),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_cin   (add_cin),
    .i_add_sum   (add_sum),
    .i_add_cout  (add_cout),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_sum   (out_sum),
    .o_out_cout  (out_cout)
  );

  // Two-stage 4-bit adder: inputs of cycle t appear at the outputs in t+2.
  // It has no reset, so stale results survive a controller reset.
  logic [4:0] add_p1 = 5'd0;
  logic [4:0] add_p2 = 5'd0;
  always @(posedge clk) begin
    add_p1 <= {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    add_p2 <= add_p1;
  end
  assign add_sum  = add_p2[3:0];
  assign add_cout = add_p2[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: mode 0 idle, 1 busy (m_rel = cycle since accept),
  // 2 result pending.
  int               m_mode = 0;
  int               m_rel  = 0;
  int               m_done = 0;
  logic [WIDTH-1:0] m_a    = '0;
  logic [WIDTH-1:0] m_b    = '0;
  logic             m_cin  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
      m_rel  <= 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          m_mode <= 1;
          m_rel  <= 1;
          m_a    <= in_a;
          m_b    <= in_b;
          m_cin  <= in_cin;
        end
        1: begin
          m_rel <= m_rel + 1;
          if (m_rel + 1 == TOTAL + 1) m_mode <= 2;
        end
        default: if (out_ready) begin
          m_mode <= 0;
          m_done <= m_done + 1;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic        issue;
    int          k;
    logic [63:0] fa, fb, mask, full, e_a, e_b, e_cin;
    fa    = 64'(m_a);
    fb    = 64'(m_b);
    full  = fa + fb + 64'(m_cin);
    issue = !rst && (m_mode == 1) && (((m_rel - 1) % STEP) == 0);
    k     = (m_rel - 1) / STEP;
    e_a   = 64'd0;
    e_b   = 64'd0;
    e_cin = 64'd0;
    if (issue) begin
      mask  = (64'd1 << (4 * k)) - 64'd1;
      e_a   = (fa >> (4 * k)) & 64'hF;
      e_b   = (fb >> (4 * k)) & 64'hF;
      e_cin = (((fa & mask) + (fb & mask) + 64'(m_cin)) >> (4 * k)) & 64'd1;
    end
    chk("in_ready", 64'(in_ready), 64'(!rst && m_mode == 0));
    chk("out_valid", 64'(out_valid), 64'(!rst && m_mode == 2));
    chk("add_a", 64'(add_a), e_a);
    chk("add_b", 64'(add_b), e_b);
    chk("add_cin", 64'(add_cin), e_cin);
    if (rst) begin
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_cout", 64'(out_cout), 64'd0);
    end else if (m_mode == 2) begin
      chk("out_sum", 64'(out_sum), full & 64'hFFFF);
      chk("out_cout", 64'(out_cout), (full >> WIDTH) & 64'd1);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
  endtask

  // One directed transaction; returns result, latency and per-slice add_cin.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int hold, output logic [15:0] s, output logic co,
                         output int lat, output logic [3:0] cins);
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = -1;
    cins = 4'd0;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(negedge clk);
      if (((c - 1) % STEP) == 0 && c <= TOTAL) cins[(c - 1) / STEP] = add_cin;
      if (out_valid) lat = c;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    s  = out_sum;
    co = out_cout;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_sum", 64'(out_sum), 64'(s));
      chk("stall_out_cout", 64'(out_cout), 64'(co));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_handshake", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [15:0] s;
    logic        co;
    int          lat;
    logic [3:0]  cins;
    logic [31:0] r;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_sum", 64'(out_sum), 64'd0);
    chk("reset_add_a", 64'(add_a), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_txn(16'h000B, 16'h0001, 1'b1, 0, s, co, lat, cins);
    chk("t1_sum", 64'(s), 64'h000D);
    chk("t1_cout", 64'(co), 64'd0);
    chk("t1_latency", 64'(lat), 64'd13);
    chk("t1_cins", 64'(cins), 64'b0001);

    run_txn(16'hFFFF, 16'h0001, 1'b0, 0, s, co, lat, cins);
    chk("t2_sum", 64'(s), 64'h0000);
    chk("t2_cout", 64'(co), 64'd1);
    chk("t2_cins", 64'(cins), 64'b1110);

    run_txn(16'hABCD, 16'h1234, 1'b1, 5, s, co, lat, cins);
    chk("t3_sum", 64'(s), 64'hBE02);
    chk("t3_cout", 64'(co), 64'd0);
    chk("t3_cins", 64'(cins), 64'b0111);

    // Reset in cycle 6 of a transaction.
    wait_ready();
    in_valid = 1'b1;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    in_cin   = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_sum", 64'(out_sum), 64'd0);
    chk("abort_out_cout", 64'(out_cout), 64'd0);
    chk("abort_add", 64'({add_a, add_b, add_cin}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_txn(16'h0E0E, 16'h0505, 1'b0, 0, s, co, lat, cins);
    chk("t4_sum", 64'(s), 64'h1313);
    chk("t4_cout", 64'(co), 64'd0);

    // Randomized traffic with random backpressure, checked by the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      r        = $urandom;
      in_valid = r[0];
      in_cin   = r[1];
      out_ready = (r[3:2] != 2'd0);
      case (r[6:4])
        3'd0:    in_a = 16'hFFFF;
        3'd1:    in_a = 16'h0000;
        default: in_a = r[31:16];
      endcase
      r = $urandom;
      case (r[18:16])
        3'd0:    in_b = 16'hFFFF;
        3'd1:    in_b = 16'h0001;
        default: in_b = r[15:0];
      endcase
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (TOTAL + 4) @(posedge clk);
    @(negedge clk);
    chk("random_txn_count", 64'(m_done >= 40), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Controller that adds two WIDTH-bit operands by sending them through the existing 4-bit, two-stage ripple-carry adder one nibble at a time. It sits directly upstream of the adder, driving its `a`/`b`/`cin` inputs. It also consumes the adder's `sum`/`cout` and chains each slice's carry-out into the next slice's carry-in. Operands arrive and results leave on valid/ready handshakes.

## Interface
- `WIDTH`, default 16: operand width; multiple of 4, range 4..64.
- `ADD_LAT`, default 2: adder latency in cycles, ≥1. A slice issued in cycle t has its result on `add_sum`/`add_cout` during cycle t+ADD_LAT.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  controller idle, can accept
- `in_a`, `in_b`  in  WIDTH  operands
- `in_cin`  in  1  initial carry-in
- `add_a`, `add_b`  out  4  nibble to adder
- `add_cin`  out  1  carry to adder
- `add_sum`  in  4  adder sum
- `add_cout`  in  1  adder carry-out
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_sum`  out  WIDTH  result sum
- `out_cout`  out  1  final carry-out

## Operation
- N = WIDTH/4 slices, processed LSB-first.
- States:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `in_a`/`in_b`, set slice index k=0 and carry reg=`in_cin`, go to ISSUE.
  - ISSUE (1 cycle): drive `add_a`=A[4k+3:4k], `add_b`=B[4k+3:4k], `add_cin`=carry reg. Load wait counter with ADD_LAT, go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter reaches the result cycle (ADD_LAT cycles after ISSUE), capture `add_sum` into result[4k+3:4k] and `add_cout` into the carry reg. If k=N-1, go to DONE; else k++ and go to ISSUE.
  - DONE: `out_valid`=1, `out_sum`=result, `out_cout`=carry reg. On `out_valid`&&`out_ready`, go to IDLE.
- Outside ISSUE, `add_a`, `add_b` and `add_cin` are driven to 0.
- Arithmetic is pure binary: {`out_cout`,`out_sum`} = `in_a` + `in_b` + `in_cin` (WIDTH+1 bits). No overflow flag.
- Only one transaction is in flight. `in_ready`=0 in ISSUE, WAIT and DONE. There is no same-cycle bypass from DONE to a new accept; `in_ready` rises in the cycle after the output handshake.
- `out_sum` and `out_cout` stay stable while `out_valid`=1 && !`out_ready`. Inputs are ignored during that time.
- Reset mid-operation:
  - Abandon the transaction and return to IDLE.
  - The wait counter clears, so adder results still in flight are never captured.
  - No partial result is emitted.

## Timing
- Reset values: state=IDLE, `in_ready`=0 while `rst`=1 (1 from the first cycle after release), `out_valid`=0, `out_sum`=0, `out_cout`=0, `add_a`=0, `add_b`=0, `add_cin`=0. Internal regs are 0.
- Accept edge = cycle 0. Slice k issues in cycle 1+k·(1+ADD_LAT) and is captured at the end of cycle (k+1)·(1+ADD_LAT).
- `out_valid` first asserts in cycle N·(1+ADD_LAT)+1. For the defaults this is cycle 13.
- Throughput: one transaction per N·(1+ADD_LAT)+2 cycles with `out_ready` held at 1.

## Structure
- Shared package holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - `NIB_W`=4;
  - a function computing N from WIDTH.
- Single module with no sub-modules. The wait counter is sized $clog2(ADD_LAT+1), and the slice index is sized $clog2(N).
- The adder is instantiated only in the bench and in the top-level integration, not inside this block.

## Test plan
Bench: this controller wired to the 4-bit two-stage adder, defaults WIDTH=16, ADD_LAT=2.
- 0x000B + 0x0001, cin=1 → `out_sum`=0x000D, `out_cout`=0. `out_valid` rises exactly 13 cycles after accept. `add_*` are 0 in every non-ISSUE cycle.
- 0xFFFF + 0x0001, cin=0 → `out_sum`=0x0000, `out_cout`=1. Carry propagates through all 4 slices: `add_cin`=1 on slices 1..3.
- 0xABCD + 0x1234, cin=1 → `out_sum`=0xBE02, `out_cout`=0.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` → outputs stay stable and `in_ready`=0. `out_ready`=1 → IDLE next cycle, `in_ready`=1.
- Assert `rst` in cycle 6 of a 0xFFFF+0xFFFF transaction:
  - all outputs go to 0 immediately;
  - after release, 0x0E0E + 0x0505 with cin=0 → 0x1313, `out_cout`=0;
  - no stale nibble from the aborted transaction appears in the result.
